// File: rtl/cpr_pkg.sv
// Shared types, widths, descriptor field offsets and the lane-extract helper
// for the write-side scheduler of the merge FIFO bank.
package cpr_pkg;

  typedef enum logic {IDLE, DATA} state_t;

  localparam int CPR_LANE_W           = 2;
  localparam int CPR_DATA_W           = 24;
  localparam int CPR_FDSTI_W          = 28;
  localparam int CPR_FDSSI_W          = 12;
  localparam int CPR_SSI_W            = 8;
  localparam int CPR_CNT_W            = 8;
  // Lane FIFO occupancy ports are CPR_FIFO_DEPTH_WIDTH+1 bits wide on the bank.
  localparam int CPR_FIFO_DEPTH_WIDTH = 4;

  localparam int INFO_W    = CPR_FDSSI_W + CPR_SSI_W + CPR_CNT_W;
  localparam int FDSSI_OFF = CPR_SSI_W + CPR_CNT_W;
  localparam int SSI_OFF   = CPR_CNT_W;
  localparam int CNT_OFF   = 0;

  // Lane index is the low lane_w bits of the target sub-domain index.
  function automatic logic [31:0] lane_of(input logic [31:0] fdsti, input int lane_w);
    return fdsti & ((32'd1 << lane_w) - 32'd1);
  endfunction

endpackage

// File: rtl/cpr_info_slot.sv
// One-lane descriptor hold register: loads on publish, holds valid until the
// merge reader acknowledges with tready.
module cpr_info_slot #(
  parameter int INFO_W = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [INFO_W-1:0] fields,
  input  logic              tready,
  output logic              tvalid,
  output logic [INFO_W-1:0] info
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid <= 1'b0;
      info   <= '0;
    end else if (load) begin
      tvalid <= 1'b1;
      info   <= fields;
    end else if (tvalid && tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/cpr_wr_sched.sv
// Write-side scheduler: steers header-framed beat blocks into lane FIFOs and
// publishes a per-lane descriptor once a block is resident. Optional FDSSI
// ordering check enabled by defining CPR_WR_SCHED_ORDER_CHK_EN.
module cpr_wr_sched
  import cpr_pkg::*;
#(
  parameter int LANE_W  = CPR_LANE_W,
  parameter int DATA_W  = CPR_DATA_W,
  parameter int FDSTI_W = CPR_FDSTI_W,
  parameter int FDSSI_W = CPR_FDSSI_W,
  parameter int SSI_W   = CPR_SSI_W,
  parameter int CNT_W   = CPR_CNT_W,
  parameter int INFO_W  = FDSSI_W + SSI_W + CNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          hdr_valid,
  output logic                          hdr_ready,
  input  logic [FDSTI_W-1:0]            hdr_fdsti,
  input  logic [FDSSI_W-1:0]            hdr_fdssi,
  input  logic [SSI_W-1:0]              hdr_ssi,
  input  logic [CNT_W-1:0]              hdr_cnt,
  input  logic                          beat_valid,
  output logic                          beat_ready,
  input  logic [DATA_W-1:0]             beat_data,
  output logic [(2**LANE_W)-1:0]        wrreq,
  output logic [DATA_W*(2**LANE_W)-1:0] data,
  input  logic [(2**LANE_W)-1:0]        full,
  output logic [(2**LANE_W)-1:0]        info_tvalid,
  input  logic [(2**LANE_W)-1:0]        info_tready,
  output logic [INFO_W*(2**LANE_W)-1:0] info,
  output logic                          busy,
  output logic                          err_zero_cnt,
  output logic                          err_order,
  output logic [15:0]                   blk_done
);

  localparam int N = 2**LANE_W;

  state_t             state_reg, state_next;
  logic [LANE_W-1:0]  lane_h, lane_reg;
  logic [FDSSI_W-1:0] fdssi_reg;
  logic [SSI_W-1:0]   ssi_reg;
  logic [CNT_W-1:0]   cnt_reg, beat_cnt_reg;
  logic [15:0]        blk_done_reg;
  logic               err_zero_reg;
  logic               hdr_acc, beat_acc, last_beat;
  logic [INFO_W-1:0]  fields;

  assign lane_h    = LANE_W'(lane_of(32'(hdr_fdsti), LANE_W));
  assign hdr_acc   = hdr_valid && hdr_ready;
  assign beat_acc  = beat_valid && beat_ready;
  assign last_beat = beat_acc && (beat_cnt_reg == cnt_reg - CNT_W'(1));
  assign fields    = {fdssi_reg, ssi_reg, cnt_reg};

  always_comb begin
    state_next = state_reg;
    hdr_ready  = 1'b0;
    beat_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        // A lane's header waits until its descriptor slot is free, so a
        // publish can never collide with a tready on the same slot.
        hdr_ready = !info_tvalid[lane_h];
        if (hdr_valid && hdr_ready && (hdr_cnt != '0))
          state_next = DATA;
      end
      DATA: begin
        beat_ready = !full[lane_reg];
        if (last_beat)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      lane_reg     <= '0;
      fdssi_reg    <= '0;
      ssi_reg      <= '0;
      cnt_reg      <= '0;
      beat_cnt_reg <= '0;
      blk_done_reg <= '0;
      err_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      err_zero_reg <= hdr_acc && (hdr_cnt == '0);
      if (hdr_acc && (hdr_cnt != '0)) begin
        lane_reg     <= lane_h;
        fdssi_reg    <= hdr_fdssi;
        ssi_reg      <= hdr_ssi;
        cnt_reg      <= hdr_cnt;
        beat_cnt_reg <= '0;
      end else if (beat_acc) begin
        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
      end
      if (last_beat)
        blk_done_reg <= blk_done_reg + 16'd1;
    end
  end

  assign busy         = (state_reg == DATA);
  assign err_zero_cnt = err_zero_reg;
  assign blk_done     = blk_done_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign wrreq[gi] = beat_acc && (lane_reg == LANE_W'(gi));
      assign data[gi*DATA_W +: DATA_W] = beat_data;

      cpr_info_slot #(
        .INFO_W (INFO_W)
      ) u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (last_beat && (lane_reg == LANE_W'(gi))),
        .fields (fields),
        .tready (info_tready[gi]),
        .tvalid (info_tvalid[gi]),
        .info   (info[gi*INFO_W +: INFO_W])
      );
    end
  endgenerate

`ifdef CPR_WR_SCHED_ORDER_CHK_EN
  logic [FDSSI_W-1:0] last_fdssi_reg [N];
  logic [N-1:0]       seen_reg;
  logic               err_order_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        last_fdssi_reg[i] <= '0;
      seen_reg      <= '0;
      err_order_reg <= 1'b0;
    end else begin
      // Zero-count headers are accepted too, so they take part in ordering.
      err_order_reg <= hdr_acc && seen_reg[lane_h] && (hdr_fdssi <= last_fdssi_reg[lane_h]);
      if (hdr_acc) begin
        last_fdssi_reg[lane_h] <= hdr_fdssi;
        seen_reg[lane_h]       <= 1'b1;
      end
    end
  end

  assign err_order = err_order_reg;
`else
  assign err_order = 1'b0;
`endif

endmodule

// File: tb/tb_cpr_wr_sched.sv
// Scoreboard bench for cpr_wr_sched: directed blocks push expected beats and
// descriptors; a negedge monitor pops and compares whatever the DUT emits.
module tb_cpr_wr_sched;

  localparam int LANE_W  = 2;
  localparam int N       = 4;
  localparam int DATA_W  = 24;
  localparam int FDSTI_W = 28;
  localparam int FDSSI_W = 12;
  localparam int SSI_W   = 8;
  localparam int CNT_W   = 8;
  localparam int INFO_W  = FDSSI_W + SSI_W + CNT_W;

  logic                 clk, rst_n;
  logic                 hdr_valid, hdr_ready;
  logic [FDSTI_W-1:0]   hdr_fdsti;
  logic [FDSSI_W-1:0]   hdr_fdssi;
  logic [SSI_W-1:0]     hdr_ssi;
  logic [CNT_W-1:0]     hdr_cnt;
  logic                 beat_valid, beat_ready;
  logic [DATA_W-1:0]    beat_data;
  logic [N-1:0]         wrreq, full, info_tvalid, info_tready;
  logic [DATA_W*N-1:0]  data;
  logic [INFO_W*N-1:0]  info;
  logic                 busy, err_zero_cnt, err_order;
  logic [15:0]          blk_done;

  cpr_wr_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hdr_valid    (hdr_valid),
    .hdr_ready    (hdr_ready),
    .hdr_fdsti    (hdr_fdsti),
    .hdr_fdssi    (hdr_fdssi),
    .hdr_ssi      (hdr_ssi),
    .hdr_cnt      (hdr_cnt),
    .beat_valid   (beat_valid),
    .beat_ready   (beat_ready),
    .beat_data    (beat_data),
    .wrreq        (wrreq),
    .data         (data),
    .full         (full),
    .info_tvalid  (info_tvalid),
    .info_tready  (info_tready),
    .info         (info),
    .busy         (busy),
    .err_zero_cnt (err_zero_cnt),
    .err_order    (err_order),
    .blk_done     (blk_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                lane;
    logic [INFO_W-1:0] info;
    logic [15:0]       blk;
  } desc_t;

  typedef struct {
    int                lane;
    logic [DATA_W-1:0] d;
  } beat_t;

  desc_t             desc_q[$];
  beat_t             beat_q[$];
  int                exp_zero, exp_order, exp_blk;
  int                checks, errors;
  logic [N-1:0]      prev_tv;
  logic [DATA_W-1:0] beat_seed;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    desc_t        e;
    beat_t        b;
    logic [N-1:0] oh;
    if (!rst_n) begin
      prev_tv = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (info_tvalid[i] && !prev_tv[i]) begin
          if (desc_q.size() == 0) begin
            check("desc_unexpected", 64'(i), 64'hFF);
          end else begin
            e = desc_q.pop_front();
            check("desc_lane", 64'(i), 64'(e.lane));
            check("desc_info", 64'(info[i*INFO_W +: INFO_W]), 64'(e.info));
            check("desc_blk_done", 64'(blk_done), 64'(e.blk));
            $display("desc lane=%0d info=0x%0h blk_done=%0d", i, info[i*INFO_W +: INFO_W], blk_done);
          end
        end
      end
      prev_tv = info_tvalid;
      if (wrreq != '0) begin
        if (beat_q.size() == 0) begin
          check("wrreq_unexpected", 64'(wrreq), 64'h0);
        end else begin
          b = beat_q.pop_front();
          oh = '0;
          oh[b.lane] = 1'b1;
          check("wrreq_onehot", 64'(wrreq), 64'(oh));
          check("beat_data", 64'(data[b.lane*DATA_W +: DATA_W]), 64'(b.d));
          $display("beat lane=%0d data=0x%0h", b.lane, b.d);
        end
      end
      if (err_zero_cnt) begin
        check("err_zero_expected", 64'(exp_zero > 0), 64'h1);
        if (exp_zero > 0) exp_zero--;
      end
      if (err_order) begin
        check("err_order_expected", 64'(exp_order > 0), 64'h1);
        if (exp_order > 0) exp_order--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_desc(input int lane, input logic [FDSSI_W-1:0] f,
                           input logic [SSI_W-1:0] s, input logic [CNT_W-1:0] c);
    desc_t e;
    exp_blk++;
    e.lane = lane;
    e.info = {f, s, c};
    e.blk  = 16'(exp_blk);
    desc_q.push_back(e);
  endtask

  task automatic send_hdr(input logic [FDSTI_W-1:0] fi, input logic [FDSSI_W-1:0] f,
                          input logic [SSI_W-1:0] s, input logic [CNT_W-1:0] c,
                          input bit expect_desc);
    int t;
    if (c == '0) exp_zero++;
    else if (expect_desc) push_desc(int'(fi[LANE_W-1:0]), f, s, c);
    hdr_valid = 1'b1;
    hdr_fdsti = fi;
    hdr_fdssi = f;
    hdr_ssi   = s;
    hdr_cnt   = c;
    t = 0;
    @(negedge clk);
    while (!hdr_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("hdr_accept", 64'(hdr_ready), 64'h1);
    $display("hdr fdsti=%0d fdssi=%0d cnt=%0d", fi, f, c);
    tick();
    hdr_valid = 1'b0;
  endtask

  task automatic send_beats(input int lane, input int n);
    int    t;
    beat_t b;
    for (int k = 0; k < n; k++) begin
      beat_seed  = beat_seed + 24'h010101;
      beat_data  = beat_seed;
      beat_valid = 1'b1;
      b.lane = lane;
      b.d    = beat_seed;
      beat_q.push_back(b);
      t = 0;
      @(negedge clk);
      while (!beat_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("beat_accept", 64'(beat_ready), 64'h1);
      check("busy_in_data", 64'(busy), 64'h1);
      tick();
    end
    beat_valid = 1'b0;
  endtask

  task automatic release_slot(input int lane);
    info_tready[lane] = 1'b1;
    tick();
    info_tready[lane] = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; exp_zero = 0; exp_order = 0; exp_blk = 0;
    beat_seed = 24'h100000;
    prev_tv = '0;
    rst_n = 1'b0;
    hdr_valid = 1'b0; hdr_fdsti = '0; hdr_fdssi = '0; hdr_ssi = '0; hdr_cnt = '0;
    beat_valid = 1'b0; beat_data = '0; full = '0; info_tready = '0;

    repeat (3) @(negedge clk);
    check("rst_wrreq", 64'(wrreq), 64'h0);
    check("rst_info_tvalid", 64'(info_tvalid), 64'h0);
    check("rst_info", 64'(info), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_blk_done", 64'(blk_done), 64'h0);
    check("rst_err_zero", 64'(err_zero_cnt), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Block on lane 1 (fdsti=5), 3 beats; descriptor visible right after last beat edge.
    send_hdr(28'd5, 12'h123, 8'h45, 8'd3, 1'b1);
    send_beats(1, 3);
    check("t1_tvalid_after_last", 64'(info_tvalid[1]), 64'h1);
    check("t1_info", 64'(info[1*INFO_W +: INFO_W]), 64'({12'h123, 8'h45, 8'd3}));
    check("t1_blk_done", 64'(blk_done), 64'h1);
    repeat (3) tick();
    check("t1_tvalid_holds", 64'(info_tvalid[1]), 64'h1);
    release_slot(1);
    check("t1_tvalid_cleared", 64'(info_tvalid[1]), 64'h0);

    // Lane 2 slot occupied: a second lane-2 header waits for info_tready[2].
    send_hdr(28'd2, 12'h200, 8'h22, 8'd1, 1'b1);
    send_beats(2, 1);
    push_desc(2, 12'h201, 8'h23, 8'd2);
    hdr_valid = 1'b1; hdr_fdsti = 28'd6; hdr_fdssi = 12'h201; hdr_ssi = 8'h23; hdr_cnt = 8'd2;
    repeat (3) begin
      @(negedge clk);
      check("blocked_hdr_ready", 64'(hdr_ready), 64'h0);
    end
    tick();
    info_tready[2] = 1'b1;
    @(negedge clk);
    check("blocked_during_tready", 64'(hdr_ready), 64'h0);
    tick();
    info_tready[2] = 1'b0;
    @(negedge clk);
    check("slot2_cleared", 64'(info_tvalid[2]), 64'h0);
    check("unblocked_hdr_ready", 64'(hdr_ready), 64'h1);
    $display("hdr fdsti=6 fdssi=513 cnt=2 (after slot release)");
    tick();
    hdr_valid = 1'b0;
    send_beats(2, 2);

    // Zero-count header on lane 0: dropped, error pulse, stays idle.
    send_hdr(28'd0, 12'h050, 8'h05, 8'd0, 1'b1);
    @(negedge clk);
    check("zero_cnt_idle", 64'(busy), 64'h0);
    check("zero_cnt_no_tvalid", 64'(info_tvalid[0]), 64'h0);
    tick();

    // Lane 0, 6 beats, full[0] stalls for 4 cycles mid-block.
    send_hdr(28'd4, 12'h300, 8'h30, 8'd6, 1'b1);
    fork
      send_beats(0, 6);
      begin
        repeat (2) @(posedge clk);
        #1 full[0] = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check("stall_beat_ready", 64'(beat_ready), 64'h0);
          check("stall_wrreq", 64'(wrreq), 64'h0);
        end
        @(posedge clk);
        #1 full[0] = 1'b0;
      end
    join
    check("t4_tvalid", 64'(info_tvalid[0]), 64'h1);

    // Asynchronous reset after 2 of 5 beats on lane 3.
    send_hdr(28'd3, 12'h400, 8'h40, 8'd5, 1'b0);
    send_beats(3, 2);
    #1 rst_n = 1'b0;
    #1;
    check("arst_wrreq", 64'(wrreq), 64'h0);
    check("arst_info_tvalid", 64'(info_tvalid), 64'h0);
    check("arst_info", 64'(info), 64'h0);
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_blk_done", 64'(blk_done), 64'h0);
    exp_blk = 0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_hdr_ready", 64'(hdr_ready), 64'h1);
    tick();
    send_hdr(28'd7, 12'h500, 8'h50, 8'd1, 1'b1);
    send_beats(3, 1);
    check("post_rst_blk_done", 64'(blk_done), 64'h1);
    release_slot(3);

`ifdef CPR_WR_SCHED_ORDER_CHK_EN
    send_hdr(28'd3, 12'd10, 8'h01, 8'd1, 1'b1);
    send_beats(3, 1);
    release_slot(3);
    send_hdr(28'd3, 12'd12, 8'h02, 8'd1, 1'b1);
    send_beats(3, 1);
    release_slot(3);
    exp_order++;
    send_hdr(28'd3, 12'd11, 8'h03, 8'd1, 1'b1);
    send_beats(3, 1);
    release_slot(3);
`endif

    repeat (5) tick();
    check("desc_q_drained", 64'(desc_q.size()), 64'h0);
    check("beat_q_drained", 64'(beat_q.size()), 64'h0);
    check("err_zero_seen", 64'(exp_zero), 64'h0);
    check("err_order_seen", 64'(exp_order), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpr_wr_sched.md
Name: cpr_wr_sched

Overview:
- Write-side scheduler for the N-lane merge FIFO bank that feeds the N-ary comparator (N = 2**LANE_W).
- Accepts one serial stream of sub-domain input blocks. Each block is a header (FDSTI, FDSSI, SSI, beat count) followed by `count` data beats.
- Steers the beats into the lane FIFO selected by FDSTI and generates per-lane `wrreq`.
- Publishes one info descriptor per completed block on the per-lane info_tvalid/info_tready handshake that the merge reader consumes.

Parameters:
- LANE_W, 2, log2 of lane count N.
- DATA_W, 24, FIFO data width.
- FDSTI_W, 28, header FDSTI width; lane = FDSTI[LANE_W-1:0].
- FDSSI_W, 12, FDSSI field width.
- SSI_W, 8, SSI field width.
- CNT_W, 8, beat-count field width.
- FIFO_DEPTH_WIDTH, 4, log2 lane FIFO depth; count ports are FIFO_DEPTH_WIDTH+1 bits.
- INFO_W, FDSSI_W+SSI_W+CNT_W, descriptor width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- hdr_valid  in  1  header valid.
- hdr_ready  out  1  header accepted when high with hdr_valid.
- hdr_fdsti  in  FDSTI_W  target sub-domain index.
- hdr_fdssi  in  FDSSI_W  block FDSSI.
- hdr_ssi  in  SSI_W  block SSI.
- hdr_cnt  in  CNT_W  beats in block.
- beat_valid  in  1  data beat valid.
- beat_ready  out  1  data beat accepted.
- beat_data  in  DATA_W  data beat.
- wrreq  out  N  one-hot FIFO write enable.
- data  out  DATA_W*N  beat_data broadcast to every lane slice.
- full  in  N  lane FIFO full.
- info_tvalid  out  N  per-lane descriptor valid.
- info_tready  in  N  per-lane descriptor consumed.
- info  out  INFO_W*N  per-lane {fdssi, ssi, cnt}; cnt occupies the low bits of the slice.
- busy  out  1  high in DATA state.
- err_zero_cnt  out  1  one-cycle pulse on a dropped zero-count header.
- blk_done  out  16  completed-block counter; wraps at 0xFFFF -> 0.

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs 0: wrreq, info_tvalid, info, busy, err pulses, blk_done.
  - The partial block latched at reset is discarded. The FIFO bank shares rst_n, so no cleanup is needed.
- FSM IDLE:
  - lane_h = hdr_fdsti[LANE_W-1:0].
  - hdr_ready = !info_tvalid[lane_h] (combinational).
  - On accept with hdr_cnt==0: the header is dropped, err_zero_cnt pulses next cycle, state stays IDLE.
  - On accept with hdr_cnt!=0: latch lane, fdssi, ssi, cnt; clear beat_cnt; go to DATA.
  - beat_ready = 0.
- FSM DATA:
  - hdr_ready = 0.
  - beat_ready = !full[lane].
  - wrreq[lane] = beat_valid && beat_ready (combinational, same cycle). All other lanes 0.
  - On each beat accept, beat_cnt increments.
  - On the accept where beat_cnt == cnt-1:
    - next cycle: info[lane] <= latched fields, info_tvalid[lane] <= 1, blk_done increments;
    - state returns to IDLE.
- Latency and throughput:
  - Header to first beat accept: 1 cycle.
  - Descriptor is valid 1 cycle after the last beat is written, so a published descriptor always refers to a fully resident block.
  - Back-to-back blocks on different lanes run at 1 header + cnt beats per block with no bubbles.
- Descriptor slot:
  - info_tvalid[i] holds until info_tready[i]; it clears the next cycle.
  - info_tready[i] while info_tvalid[i]==0 is ignored.
  - Publish and tready cannot collide on the same lane, because a header for a lane is accepted only while that slot is free.
- Backpressure:
  - A full lane stalls beats only; the header and beat counter hold.
  - full asserting on the last beat delays the descriptor publish.
- Width rules:
  - beat_cnt is CNT_W bits.
  - cnt-1 is computed in CNT_W bits; cnt==0 never reaches DATA.

Optional Feature:
- Macro: CPR_WR_SCHED_ORDER_CHK_EN.
- Defined:
  - Each lane keeps a last_fdssi register and a seen flag.
  - Accepting a header whose hdr_fdssi <= last_fdssi[lane] (when seen) pulses output err_order for one cycle. The block is still processed.
  - last_fdssi and seen clear on reset.
- Undefined:
  - err_order is tied 0 and the per-lane registers are absent.

Decomposition:
- Package cpr_pkg holds:
  - the state enum {IDLE, DATA};
  - INFO_W and the field offsets FDSSI_OFF = SSI_W+CNT_W, SSI_OFF = CNT_W, CNT_OFF = 0;
  - a lane-extract function.
- Sub-module cpr_info_slot, instantiated N times:
  - one-lane descriptor hold register;
  - ports: load, fields, tready, tvalid, info.

Test Plan:
- Header fdsti=5, cnt=3, then 3 beats with N=4 -> wrreq=4'b0010 on 3 cycles; info_tvalid[1] rises 1 cycle after the 3rd beat with info[1]={fdssi,ssi,8'd3}; blk_done=1.
- Lane 2 descriptor pending (tready=0), new header fdsti=2 -> hdr_ready=0 until info_tready[2] pulses; accepted the following cycle.
- hdr_cnt=0 -> hdr_ready=1, err_zero_cnt pulses once, no wrreq, no info_tvalid, state stays IDLE.
- full[0] high for 4 cycles mid-block (cnt=6, lane 0) -> beat_ready=0 for those cycles, total wrreq count=6, descriptor published after the 6th beat.
- rst_n low after 2 of 5 beats -> all outputs 0 asynchronously; after release a new header is accepted in IDLE.
- With CPR_WR_SCHED_ORDER_CHK_EN defined: lane 3 fdssi sequence 10, 12, 11 -> err_order pulses only on the third header.
